mdu_sequencer: RTL and testbench

//  Iterative unsigned multiply/divide unit (MULTU/DIVU) for the EX stage that owns no adder of its own.

---
 rtl/mdu_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// ============================================================================
// mdu_sequencer
// ----------------------------------------------------------------------------
// Iterative unsigned multiply/divide unit (MULTU / DIVU) for the EX stage.
// It has no adder of its own. While an operation runs, it takes over the
// shared ALU and performs one add or subtract per cycle. HI/LO hold the last
// completed result for MFHI/MFLO. While the unit is busy, it stalls the
// pipeline.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, op_div        request (sampled only in IDLE); 0 = MULTU, 1 = DIVU
//   rs_val, rt_val       multiplicand/dividend, multiplier/divisor
//   ex_alu_a/b/ctrl/src  EX-stage ALU request (passed through when idle)
//   alu_result           shared ALU result (combinational from alu_a/b/ctrl)
//   alu_a/b/ctrl/src     arbitrated ALU inputs
//   busy, ex_stall       high while not IDLE
//   done                 one-cycle pulse in the cycle hi/lo show a new result
//   hi, lo               HI/LO result registers
// ============================================================================
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] ex_alu_a,
    input  logic [WIDTH-1:0] ex_alu_b,
    input  logic [3:0]       ex_alu_ctrl,
    input  logic             ex_alu_src,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_src,
    output logic             busy,
    output logic             ex_stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_count;
    logic             r_op_div;
    // r_acc: P_hi (MULTU) or partial remainder R (DIVU)
    // r_low: P_lo (MULTU) or quotient/dividend shifter Q (DIVU)
    // r_opd: multiplicand M (MULTU) or divisor D (DIVU)
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_opd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_last;
    logic             w_div0;
    logic [WIDTH:0]   w_s;
    logic [WIDTH-1:0] w_t;
    logic             w_carry;
    logic             w_sub_ok;
    logic [WIDTH-1:0] w_seq_a;
    logic [WIDTH-1:0] w_seq_b;
    logic [3:0]       w_seq_ctrl;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_low_nxt;

    assign w_last = (r_count == CNT_W'(WIDTH - 1));
    assign w_div0 = op_div && (rt_val == '0);

    // Restoring division: shift the next dividend bit into the remainder.
    // s is one bit wider, so a remainder that overflows the shift still
    // counts as >= D.
    assign w_s      = {r_acc, r_low[WIDTH-1]};
    assign w_t      = w_s[WIDTH-1:0];
    assign w_sub_ok = w_s[WIDTH] || (w_t >= r_opd);

    // The ALU does not export a carry, so it is recovered from wraparound.
    assign w_carry = (alu_result < r_acc);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        w_seq_a    = r_acc;
        w_seq_b    = r_low[0] ? r_opd : '0;
        w_seq_ctrl = ALU_ADD;
        w_acc_nxt  = {w_carry, alu_result[WIDTH-1:1]};
        w_low_nxt  = {alu_result[0], r_low[WIDTH-1:1]};
        if (r_op_div) begin
            w_seq_a    = w_t;
            w_seq_b    = r_opd;
            w_seq_ctrl = ALU_SUB;
            w_acc_nxt  = w_sub_ok ? alu_result : w_t;
            w_low_nxt  = {r_low[WIDTH-2:0], w_sub_ok};
        end
    end

    // ALU arbitration: EX owns the ALU only while the sequencer is idle.
    always_comb begin
        alu_a    = ex_alu_a;
        alu_b    = ex_alu_b;
        alu_ctrl = ex_alu_ctrl;
        alu_src  = ex_alu_src;
        if (r_state != IDLE) begin
            alu_a    = w_seq_a;
            alu_b    = w_seq_b;
            alu_ctrl = w_seq_ctrl;
            alu_src  = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_div0 ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the edge.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_op_div <= 1'b0;
            r_acc    <= '0;
            r_low    <= '0;
            r_opd    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_div <= op_div;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_low    <= op_div ? rs_val : rt_val;
                        r_opd    <= op_div ? rt_val : rs_val;
                        if (w_div0) begin
                            r_hi <= rs_val;
                            r_lo <= '1;
                        end
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_low   <= w_low_nxt;
                    r_count <= r_count + CNT_W'(1);
                    // The final iteration's result goes straight into HI/LO,
                    // so the new values are visible in the DONE cycle.
                    if (w_last) begin
                        r_hi <= w_acc_nxt;
                        r_lo <= w_low_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign ex_stall = busy;
    assign done     = (r_state == DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// ============================================================================
// tb_mdu_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for mdu_sequencer. A small ALU model closes the loop on
// alu_result. A table of MULTU/DIVU vectors with hand-computed results is
// applied in a loop. Hand-written sequences cover reset state, idle
// passthrough, start held high, and reset in the middle of an operation.
// ============================================================================
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_div;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic [W-1:0] ex_alu_a;
    logic [W-1:0] ex_alu_b;
    logic [3:0]   ex_alu_ctrl;
    logic         ex_alu_src;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic         alu_src;
    logic         busy;
    logic         ex_stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Shared ALU: add for 0010, subtract for 0110, AND otherwise.
    always_comb begin
        alu_result = alu_a & alu_b;
        if (alu_ctrl == 4'b0010) alu_result = alu_a + alu_b;
        else if (alu_ctrl == 4'b0110) alu_result = alu_a - alu_b;
    end

    mdu_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_div      (op_div),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .ex_alu_a    (ex_alu_a),
        .ex_alu_b    (ex_alu_b),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_alu_src  (ex_alu_src),
        .alu_result  (alu_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .busy        (busy),
        .ex_stall    (ex_stall),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to completion. Sampling happens on
    // negedges. lat counts cycles after the start edge, so the DONE cycle of
    // a full operation is lat = 33.
    task automatic run_op(input string name, input logic op, input logic [W-1:0] rs,
                          input logic [W-1:0] rt, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int exp_lat,
                          input logic hold_start);
        int lat;
        int busy_gaps;
        int stall_mism;
        int early_done;
        @(negedge clk);
        start       = 1'b1;
        op_div      = op;
        rs_val      = rs;
        rt_val      = rt;
        ex_alu_src  = 1'b1;
        ex_alu_ctrl = 4'b0000;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        @(negedge clk);
        lat        = 1;
        busy_gaps  = 0;
        stall_mism = 0;
        early_done = 0;
        if (exp_lat > 1) begin
            check({name, " first_ctrl"}, {28'd0, alu_ctrl}, op ? 32'h6 : 32'h2);
            check({name, " first_src"}, {31'd0, alu_src}, 32'd0);
            check({name, " first_a"}, alu_a, op ? {31'd0, rs[W-1]} : 32'd0);
            check({name, " first_b"}, alu_b, op ? rt : (rt[0] ? rs : 32'd0));
        end
        while (!done && lat < 40) begin
            if (!busy) busy_gaps++;
            if (ex_stall !== busy) stall_mism++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy_run"}, busy_gaps, 0);
        check({name, " stall_eq_busy"}, stall_mism, 0);
        check({name, " busy_done"}, {31'd0, busy}, 32'd1);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        // If start is still high at the DONE edge, the unit must not restart.
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({name, " idle_busy"}, {31'd0, busy}, 32'd0);
        check({name, " idle_done"}, {31'd0, done}, 32'd0);
        check({name, " hold_hi"}, hi, exp_hi);
        check({name, " hold_lo"}, lo, exp_lo);
    endtask

    initial begin
        int done_seen;
        vecs[0] = '{"mul7x6",   1'b0, 32'd7,        32'd6,        32'd0,        32'd42,       33};
        vecs[1] = '{"mulmax",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[2] = '{"mulhib",   1'b0, 32'h80000000, 32'd2,        32'd1,        32'd0,        33};
        vecs[3] = '{"div100_7", 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[4] = '{"divmax_1", 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};
        vecs[5] = '{"div5_9",   1'b1, 32'd5,        32'd9,        32'd5,        32'd0,        33};
        vecs[6] = '{"div0",     1'b1, 32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, 1};
        vecs[7] = '{"divhib_3", 1'b1, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 33};
        vecs[8] = '{"divmaxmx", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        33};

        reset       = 1'b1;
        start       = 1'b0;
        op_div      = 1'b0;
        rs_val      = '0;
        rt_val      = '0;
        ex_alu_a    = 32'd3;
        ex_alu_b    = 32'd4;
        ex_alu_ctrl = 4'b0010;
        ex_alu_src  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and idle passthrough.
        @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("idle alu_a", alu_a, 32'd3);
        check("idle alu_b", alu_b, 32'd4);
        check("idle alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
        check("idle alu_src", {31'd0, alu_src}, 32'd1);
        check("idle ex_stall", {31'd0, ex_stall}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat, 1'b0);
        end

        // Start held high through RUN and DONE: exactly one operation.
        run_op("hold", 1'b0, 32'd9, 32'd11, 32'd0, 32'd99, 33, 1'b1);

        // Passthrough after an operation has finished.
        ex_alu_a    = 32'h1111;
        ex_alu_b    = 32'h2222;
        ex_alu_ctrl = 4'b0110;
        ex_alu_src  = 1'b0;
        @(negedge clk);
        check("post alu_a", alu_a, 32'h1111);
        check("post alu_b", alu_b, 32'h2222);
        check("post alu_ctrl", {28'd0, alu_ctrl}, 32'h6);

        // Reset during RUN at count = 10 (cycle k+11 after the start edge).
        @(negedge clk);
        start  = 1'b1;
        op_div = 1'b0;
        rs_val = 32'hDEADBEEF;
        rt_val = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("abort no_done", done_seen, 0);
        run_op("mul3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
